// File: rtl/uart_frame_gather_if.sv
// Byte-stream bundle between the UART receiver, the frame gatherer and the per-type decoders.
// The slave modport is the gatherer; the master modport is its environment.
interface uart_frame_gather_if #(
    parameter int TYPE_W = 2
);
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic [7:0]        o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_last;
    logic [TYPE_W-1:0] o_type;
    logic [7:0]        o_len;
    logic              o_frame_ok;
    logic              o_chk_err;
    logic              o_fmt_err;
    logic              o_timeout;
    logic              o_drop;
    logic              o_busy;

    modport master (
        output i_rx_data, i_rx_valid, i_ready,
        input  o_data, o_valid, o_last, o_type, o_len,
        input  o_frame_ok, o_chk_err, o_fmt_err, o_timeout, o_drop, o_busy
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_ready,
        output o_data, o_valid, o_last, o_type, o_len,
        output o_frame_ok, o_chk_err, o_fmt_err, o_timeout, o_drop, o_busy
    );
endinterface

// File: rtl/uart_frame_gather.sv
// Parses HEAD,TYPE,LEN,payload,CHK frames from a UART byte stream and replays
// the payload of checksum-clean frames on a valid/ready stream.
module uart_frame_gather #(
    parameter logic [7:0] HEAD        = 8'hA5,
    parameter int         TYPE_NUM    = 4,
    parameter int         TYPE_W      = 2,
    parameter int         MAX_LEN     = 32,
    parameter int         TIMEOUT_CYC = 1000
) (
    input logic               i_clk,
    input logic               i_rst_n,
    uart_frame_gather_if.slave bus
);
    localparam int          AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [15:0] TMO_MAX  = 16'(TIMEOUT_CYC - 1);
    localparam logic [8:0]  TYPE_LIM = 9'(TYPE_NUM);
    localparam logic [7:0]  LEN_LIM  = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_TYPE, S_LEN, S_DATA, S_CHK, S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        pay_mem [2**AW];
    logic [7:0]        sum_q, len_q, wr_ptr, rd_ptr;
    logic [TYPE_W-1:0] typ_q;
    logic [15:0]       idle_q;

    logic [7:0]        data_q, olen_q;
    logic [TYPE_W-1:0] otyp_q;
    logic              valid_q, last_q;
    logic              ok_q, chk_q, fmt_q, tmo_q, drop_q;

    logic [7:0] rx;
    logic       rx_v, counting, beat;
    logic       fmt_bad, chk_ok, chk_bad, tmo, drop;

    assign rx       = bus.i_rx_data;
    assign rx_v     = bus.i_rx_valid;
    assign beat     = valid_q && bus.i_ready;
    assign counting = (state_q == S_TYPE) || (state_q == S_LEN) ||
                      (state_q == S_DATA) || (state_q == S_CHK);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        fmt_bad = 1'b0;
        chk_ok  = 1'b0;
        chk_bad = 1'b0;
        tmo     = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            S_IDLE: if (rx_v && rx == HEAD) state_d = S_TYPE;
            S_TYPE: if (rx_v) begin
                if ({1'b0, rx} >= TYPE_LIM) begin
                    fmt_bad = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LEN;
                end
            end
            S_LEN: if (rx_v) begin
                if (rx > LEN_LIM) begin
                    fmt_bad = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = (rx == 8'd0) ? S_CHK : S_DATA;
                end
            end
            S_DATA: if (rx_v && wr_ptr == len_q - 8'd1) state_d = S_CHK;
            S_CHK: if (rx_v) begin
                if (rx == sum_q) begin
                    chk_ok  = 1'b1;
                    state_d = (len_q == 8'd0) ? S_IDLE : S_OUT;
                end else begin
                    chk_bad = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_OUT: begin
                // No backpressure toward the UART: anything arriving now is lost.
                drop = rx_v;
                if (beat && last_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (counting && !rx_v && idle_q == TMO_MAX) begin
            tmo     = 1'b1;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (state_q == S_DATA && rx_v) pay_mem[wr_ptr[AW-1:0]] <= rx;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum_q   <= '0;
            len_q   <= '0;
            typ_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            idle_q  <= '0;
            data_q  <= '0;
            olen_q  <= '0;
            otyp_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ok_q    <= 1'b0;
            chk_q   <= 1'b0;
            fmt_q   <= 1'b0;
            tmo_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            ok_q   <= chk_ok;
            chk_q  <= chk_bad;
            fmt_q  <= fmt_bad;
            tmo_q  <= tmo;
            drop_q <= drop;

            if (rx_v || !counting) idle_q <= '0;
            else                   idle_q <= idle_q + 16'd1;

            if (rx_v) begin
                case (state_q)
                    S_TYPE: begin
                        typ_q <= rx[TYPE_W-1:0];
                        sum_q <= rx;
                    end
                    S_LEN: begin
                        len_q  <= rx;
                        sum_q  <= sum_q + rx;
                        wr_ptr <= '0;
                    end
                    S_DATA: begin
                        sum_q  <= sum_q + rx;
                        wr_ptr <= wr_ptr + 8'd1;
                    end
                    default: ;
                endcase
            end

            // rd_ptr always names the buffer slot of the next beat to present.
            if (chk_ok) begin
                otyp_q <= typ_q;
                olen_q <= len_q;
                if (len_q != 8'd0) begin
                    valid_q <= 1'b1;
                    data_q  <= pay_mem[0];
                    last_q  <= (len_q == 8'd1);
                    rd_ptr  <= 8'd1;
                end
            end else if (beat) begin
                if (last_q) begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end else begin
                    data_q <= pay_mem[rd_ptr[AW-1:0]];
                    last_q <= (rd_ptr == len_q - 8'd1);
                    rd_ptr <= rd_ptr + 8'd1;
                end
            end
        end
    end

    assign bus.o_data     = data_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_last     = last_q;
    assign bus.o_type     = otyp_q;
    assign bus.o_len      = olen_q;
    assign bus.o_frame_ok = ok_q;
    assign bus.o_chk_err  = chk_q;
    assign bus.o_fmt_err  = fmt_q;
    assign bus.o_timeout  = tmo_q;
    assign bus.o_drop     = drop_q;
    assign bus.o_busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_frame_gather.sv
// Randomised scoreboard bench for uart_frame_gather: frames are classified from
// the framing rules, expectations are queued, and a monitor checks every output.
module tb_uart_frame_gather;
    localparam int         TW   = 2;
    localparam int         TN   = 4;
    localparam int         MAXL = 32;
    localparam int         T    = 20;
    localparam logic [7:0] HEAD = 8'hA5;

    localparam int EV_NONE = -1, EV_OK = 0, EV_CHK = 1, EV_FMT = 2, EV_TMO = 3, EV_DROP = 4;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int            k;
        logic [TW-1:0] t;
        logic [7:0]    n;
    } ev_t;
    typedef struct {
        logic [7:0]    d;
        logic          l;
        logic [TW-1:0] t;
        logic [7:0]    n;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_err = 0;
    int   ready_mode = 0;

    ev_t   exp_ev[$];
    beat_t exp_beat[$];

    uart_frame_gather_if #(.TYPE_W(TW)) bus ();

    uart_frame_gather #(
        .HEAD(HEAD), .TYPE_NUM(TN), .TYPE_W(TW), .MAX_LEN(MAXL), .TIMEOUT_CYC(T)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outcome of a frame purely from the framing rules.
    function automatic int frame_kind(input bq_t f);
        int s;
        int len;
        if (f.size() < 2) return EV_NONE;
        if (int'(f[1]) >= TN) return EV_FMT;
        if (f.size() < 3) return EV_NONE;
        if (int'(f[2]) > MAXL) return EV_FMT;
        len = int'(f[2]);
        if (f.size() < len + 4) return EV_NONE;
        s = 0;
        for (int i = 1; i < len + 3; i++) s += int'(f[i]);
        return (int'(f[len + 3]) == s % 256) ? EV_OK : EV_CHK;
    endfunction

    task automatic expect_frame(input bq_t f);
        int    k;
        ev_t   e;
        beat_t b;
        k = frame_kind(f);
        if (k == EV_NONE) return;
        e.k = k;
        e.t = f[1][TW-1:0];
        e.n = (f.size() > 2) ? f[2] : 8'd0;
        exp_ev.push_back(e);
        if (k == EV_OK) begin
            for (int i = 0; i < int'(f[2]); i++) begin
                b.d = f[3 + i];
                b.l = (i == int'(f[2]) - 1);
                b.t = e.t;
                b.n = e.n;
                exp_beat.push_back(b);
            end
        end
    endtask

    task automatic push_ev(input int k);
        ev_t e;
        e.k = k;
        e.t = '0;
        e.n = '0;
        exp_ev.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        tick();
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bq_t f, input int gmax);
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i]);
            if (i != f.size() - 1) repeat ($urandom_range(0, gmax)) tick();
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.o_busy || bus.o_valid) && n < 2000) begin
            tick();
            n++;
        end
        check("drain_bound", n < 2000, 1);
        tick();
    endtask

    initial begin
        bus.i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.i_ready = 1'b1;
                1:       bus.i_ready = ~bus.i_ready;
                2:       bus.i_ready = 1'($urandom_range(0, 1));
                default: bus.i_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every pulse consumes one expected event, every transfer one beat.
    logic [4:0] mon_p;
    logic       prev_stall;
    logic [7:0] prev_data;
    ev_t        mon_e;
    beat_t      mon_b;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            mon_p = {bus.o_drop, bus.o_timeout, bus.o_fmt_err, bus.o_chk_err, bus.o_frame_ok};
            if (mon_p != 5'd0) begin
                check("pulse_onehot", $countones(mon_p), 1);
                check("event_expected", exp_ev.size() != 0, 1);
                if (exp_ev.size() != 0) begin
                    mon_e = exp_ev.pop_front();
                    check("event_kind", 32'(mon_p), 32'd1 << mon_e.k);
                    if (mon_e.k == EV_OK) begin
                        check("ok_type", 32'(bus.o_type), 32'(mon_e.t));
                        check("ok_len", 32'(bus.o_len), 32'(mon_e.n));
                    end
                end
            end
            if (bus.o_valid) begin
                if (prev_stall) check("stall_hold", bus.o_data, prev_data);
                if (bus.i_ready) begin
                    check("beat_expected", exp_beat.size() != 0, 1);
                    if (exp_beat.size() != 0) begin
                        mon_b = exp_beat.pop_front();
                        check("beat_data", bus.o_data, mon_b.d);
                        check("beat_last", bus.o_last, mon_b.l);
                        check("beat_type", 32'(bus.o_type), 32'(mon_b.t));
                        check("beat_len", bus.o_len, mon_b.n);
                    end
                end
            end
            prev_stall = bus.o_valid && !bus.i_ready;
            prev_data  = bus.o_data;
        end
    end

    initial begin
        bq_t        f;
        int         kind, len, s;
        logic [7:0] t, b;

        rst_n          = 1'b0;
        bus.i_rx_data  = '0;
        bus.i_rx_valid = 1'b0;
        #1;
        check("rst_valid", bus.o_valid, 0);
        check("rst_data", bus.o_data, 0);
        check("rst_type", 32'(bus.o_type), 0);
        check("rst_len", bus.o_len, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_pulses", {bus.o_frame_ok, bus.o_chk_err, bus.o_fmt_err, bus.o_timeout, bus.o_drop}, 0);
        #20;
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Leading garbage is ignored, then a clean frame with 1-clock latency.
        send_byte(8'h00);
        send_byte(8'hFF);
        check("garbage_idle", bus.o_busy, 0);
        f = '{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h64};
        expect_frame(f);
        send_frame(f, 0);
        check("lat_ok", bus.o_frame_ok, 1);
        check("lat_valid", bus.o_valid, 1);
        check("lat_data0", bus.o_data, 8'h10);
        check("lat_type", 32'(bus.o_type), 1);
        check("lat_len", bus.o_len, 3);
        tick();
        check("seq_data1", bus.o_data, 8'h20);
        tick();
        check("seq_data2", bus.o_data, 8'h30);
        check("seq_last", bus.o_last, 1);
        tick();
        check("seq_drop_valid", bus.o_valid, 0);
        check("seq_idle", bus.o_busy, 0);
        wait_idle();

        // Backpressure plus a byte landing mid-output.
        ready_mode = 1;
        expect_frame(f);
        send_frame(f, 0);
        tick();
        push_ev(EV_DROP);
        send_byte(8'h55);
        wait_idle();
        ready_mode = 0;
        expect_frame(f);
        send_frame(f, 1);
        wait_idle();

        // Error frames, zero length, checksum wraparound.
        f = '{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h65};
        expect_frame(f); send_frame(f, 0); wait_idle();
        f = '{8'hA5, 8'h04};
        expect_frame(f); send_frame(f, 0); wait_idle();
        f = '{8'hA5, 8'h00, 8'h21};
        expect_frame(f); send_frame(f, 0); wait_idle();
        f = '{8'hA5, 8'h02, 8'h00, 8'h02};
        expect_frame(f); send_frame(f, 0);
        check("zero_len_no_valid", bus.o_valid, 0);
        check("zero_len_type", 32'(bus.o_type), 2);
        wait_idle();
        f = '{8'hA5, 8'h03, 8'h02, 8'hFF, 8'hFF, 8'h03};
        expect_frame(f); send_frame(f, 0); wait_idle();

        // Timeout: silence expires, and a byte on the last allowed clock survives.
        push_ev(EV_TMO);
        send_byte(HEAD);
        send_byte(8'h01);
        repeat (T - 1) tick();
        check("tmo_busy_before", bus.o_busy, 1);
        tick();
        check("tmo_busy_after", bus.o_busy, 0);
        wait_idle();
        f = '{8'hA5, 8'h01, 8'h00, 8'h01};
        expect_frame(f);
        send_byte(HEAD);
        send_byte(8'h01);
        repeat (T - 1) tick();
        send_byte(8'h00);
        check("tmo_edge_busy", bus.o_busy, 1);
        send_byte(8'h01);
        wait_idle();

        // Async reset in the middle of a stalled output.
        ready_mode = 3;
        f = '{8'hA5, 8'h02, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hB0};
        expect_frame(f);
        send_frame(f, 0);
        check("ar_valid_before", bus.o_valid, 1);
        tick();
        tick();
        #3 rst_n = 1'b0;
        #1;
        check("ar_valid", bus.o_valid, 0);
        check("ar_busy", bus.o_busy, 0);
        check("ar_data", bus.o_data, 0);
        exp_beat.delete();
        #10;
        @(negedge clk) rst_n = 1'b1;
        ready_mode = 1;
        tick();
        f = '{8'hA5, 8'h03, 8'h02, 8'h7E, 8'h01, 8'h84};
        expect_frame(f); send_frame(f, 0); wait_idle();

        // Random frames of every class.
        for (int i = 0; i < 40; i++) begin
            ready_mode = $urandom_range(0, 2);
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    b = 8'($urandom);
                    if (b == HEAD) b = 8'h00;
                    send_byte(b);
                end
            end
            t   = 8'($urandom_range(0, TN - 1));
            len = ($urandom_range(0, 7) == 0) ? MAXL : $urandom_range(0, 8);
            f   = '{HEAD, t, 8'(len)};
            s   = int'(t) + len;
            for (int j = 0; j < len; j++) begin
                b = 8'($urandom);
                f.push_back(b);
                s += int'(b);
            end
            f.push_back(8'(s));
            if (kind == 6) f[f.size() - 1] = 8'(s + $urandom_range(1, 255));
            if (kind == 7) f = '{HEAD, 8'($urandom_range(TN, 255))};
            if (kind == 8) f = '{HEAD, t, 8'($urandom_range(MAXL + 1, 255))};
            if (kind == 9) begin
                f = '{HEAD, t};
                push_ev(EV_TMO);
                send_frame(f, 2);
                repeat (T + 1) tick();
            end else begin
                expect_frame(f);
                send_frame(f, 2);
            end
            wait_idle();
        end

        repeat (5) tick();
        check("events_left", exp_ev.size(), 0);
        check("beats_left", exp_beat.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
